if_stage: RTL and testbench

//  - Instruction fetch stage directly upstream of the control unit.
//  - Holds the fetch PC and issues single-outstanding requests to instruction memory.
//  - Buffers returned words in a small FIFO and presents the head instruction to decode.
//  - Splits the head into opcode/funct fields and flags fetch-side exceptions (misaligned, access fault).

---
 rtl/if_stage_if.sv | 36 +++
 rtl/if_stage.sv | 162 ++++++++++++++++
 tb/tb_if_stage.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/if_stage_if.sv
// Fetch-stage bundle: redirect/stall from the pipeline, imem request/response, decode-facing head entry.
// Ports: redirect_valid/redirect_pc, stall, imem_req/imem_addr/imem_ack/imem_rdata/imem_err,
//        valid_o/pc_o/instr_o, opcode/funct3/funct7/funct12, RaiseExcep/ExcepCode.
interface if_stage_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        imem_err;
  logic        valid_o;
  logic [31:0] pc_o;
  logic [31:0] instr_o;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [11:0] funct12;
  logic        RaiseExcep;
  logic [3:0]  ExcepCode;

  // master: the fetch stage itself
  modport master (
    input  redirect_valid, redirect_pc, stall, imem_ack, imem_rdata, imem_err,
    output imem_req, imem_addr, valid_o, pc_o, instr_o, opcode, funct3, funct7,
           funct12, RaiseExcep, ExcepCode
  );

  // slave: pipeline + instruction memory around the fetch stage
  modport slave (
    output redirect_valid, redirect_pc, stall, imem_ack, imem_rdata, imem_err,
    input  imem_req, imem_addr, valid_o, pc_o, instr_o, opcode, funct3, funct7,
           funct12, RaiseExcep, ExcepCode
  );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch: holds fetch PC, single-outstanding imem requests, small buffer feeding decode.
// Latency: registered imem_req; head fields are combinational from the buffer (>=2 cycles req->valid_o).
// Backpressure: stall holds the head entry; requests stop when the buffer has no room.
// Ports: clk, rst (async active-high), bus (if_stage_if.master).
// Option: IF_PREFETCH_EN -- when defined, the buffer fills up to DEPTH ahead of decode;
//         otherwise effective depth is 1 (request only when empty or popping).
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic       clk,
  input  logic       rst,
  if_stage_if.master bus
);
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int unsigned PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW  = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {ST_FETCH, ST_WAIT, ST_DRAIN} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        exc;
    logic [3:0]  code;
  } ent_t;

  state_t         r_state, w_state_nxt;
  logic           r_req;
  logic [31:0]    r_addr;
  logic [31:0]    r_pc;
  logic           r_halted;
  ent_t           r_mem [DEPTH];
  logic [PW-1:0]  r_wptr, r_rptr;
  logic [CW-1:0]  r_count;

  logic           w_valid, w_pop, w_space, w_issue, w_push, w_take, w_halt_set, w_adv_pc;
  logic [PW-1:0]  w_wptr_nxt, w_rptr_nxt;
  logic [31:0]    w_instr;
  ent_t           w_push_ent, w_head;

  assign w_valid = (r_count != '0);
  assign w_head  = r_mem[r_rptr];
  // Redirect flushes the buffer, so it also suppresses the pop.
  assign w_pop   = w_valid && !bus.stall && !bus.redirect_valid;
  // An ack only belongs to us while a request is outstanding; after reset it is ignored.
  assign w_take  = bus.imem_ack && (r_state != ST_FETCH);

`ifdef IF_PREFETCH_EN
  // In FETCH nothing is in flight, so occupancy alone bounds the next request.
  assign w_space = (r_count < CW'(DEPTH));
`else
  assign w_space = (r_count == '0) || ((r_count == CW'(1)) && w_pop);
`endif

  assign w_wptr_nxt = (DEPTH == 1) ? '0 : r_wptr + PW'(1);
  assign w_rptr_nxt = (DEPTH == 1) ? '0 : r_rptr + PW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_FETCH;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_push      = 1'b0;
    w_push_ent  = '0;
    w_halt_set  = 1'b0;
    w_adv_pc    = 1'b0;
    unique case (r_state)
      ST_FETCH: begin
        if (!bus.redirect_valid && !r_halted && w_space) begin
          if (r_pc[1:0] != 2'b00) begin
            // Misaligned target: report it through the buffer instead of fetching.
            w_push     = 1'b1;
            w_push_ent = '{pc: r_pc, instr: NOP, exc: 1'b1, code: 4'd0};
            w_halt_set = 1'b1;
          end else begin
            w_issue     = 1'b1;
            w_state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (bus.imem_ack) begin
          w_state_nxt = ST_FETCH;
          // A redirect in the ack cycle wins: the returned word is dropped.
          if (!bus.redirect_valid) begin
            w_push     = 1'b1;
            w_adv_pc   = 1'b1;
            w_halt_set = bus.imem_err;
            w_push_ent = '{pc:    r_addr,
                           instr: bus.imem_err ? NOP : bus.imem_rdata,
                           exc:   bus.imem_err,
                           code:  bus.imem_err ? 4'd1 : 4'd0};
          end
        end else if (bus.redirect_valid) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (bus.imem_ack) w_state_nxt = ST_FETCH;
      end
      default: w_state_nxt = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req    <= 1'b0;
      r_addr   <= RESET_PC;
      r_pc     <= RESET_PC;
      r_halted <= 1'b0;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
    end else begin
      // imem_addr is a separate register so a redirect cannot disturb an in-flight request.
      if (w_issue) begin
        r_req  <= 1'b1;
        r_addr <= r_pc;
      end else if (w_take) begin
        r_req  <= 1'b0;
      end

      if (bus.redirect_valid) r_pc <= bus.redirect_pc;
      else if (w_adv_pc)      r_pc <= r_addr + 32'd4;

      if (bus.redirect_valid) r_halted <= 1'b0;
      else if (w_halt_set)    r_halted <= 1'b1;

      if (bus.redirect_valid) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) r_wptr <= w_wptr_nxt;
        if (w_pop)  r_rptr <= w_rptr_nxt;
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  // Storage needs no reset: entries are only visible through r_count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_push_ent;
  end

  assign w_instr        = w_valid ? w_head.instr : NOP;
  assign bus.imem_req   = r_req;
  assign bus.imem_addr  = r_addr;
  assign bus.valid_o    = w_valid;
  assign bus.pc_o       = w_valid ? w_head.pc : 32'd0;
  assign bus.instr_o    = w_instr;
  assign bus.opcode     = w_instr[6:0];
  assign bus.funct3     = w_instr[14:12];
  assign bus.funct7     = w_instr[31:25];
  assign bus.funct12    = w_instr[31:20];
  assign bus.RaiseExcep = w_valid && w_head.exc;
  assign bus.ExcepCode  = w_valid ? w_head.code : 4'd0;
endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: directed scenarios plus random traffic against a queue-based reference model.
// Latency: model predicts every cycle's outputs; outputs sampled on the falling edge.
// Backpressure: stall and ack timing are randomized; the model tracks buffer room.
module tb_if_stage;
  localparam logic [31:0] RESET_PC = 32'h0000_0100;
  localparam int unsigned DEPTH    = 2;
  localparam logic [31:0] NOP      = 32'h0000_0013;
`ifdef IF_PREFETCH_EN
  localparam int EFF = DEPTH;
`else
  localparam int EFF = 1;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        exc;
    logic [3:0]  code;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  if_stage_if bus();
  if_stage #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;
  int n_req_seen = 0;
  logic [31:0] fetched[$];

  // Reference model: buffered entries, fetch PC, halt flag, one outstanding request.
  ent_t        mq[$];
  logic [31:0] m_pc, m_addr;
  bit          m_halted, m_busy, m_discard;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h, required %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pc = RESET_PC; m_addr = RESET_PC;
    m_halted = 0; m_busy = 0; m_discard = 0;
  endtask

  task automatic model_step(input bit rv, input logic [31:0] rpc, input bit st,
                            input bit ak, input logic [31:0] rd, input bit er);
    bit pop, space, have;
    ent_t e;
    pop  = (mq.size() != 0) && !st && !rv;
    have = 0;
    e    = '0;
    if (EFF == 1) space = (mq.size() == 0) || (mq.size() == 1 && pop);
    else          space = (mq.size() < EFF);
    if (m_busy) begin
      if (ak) begin
        m_busy = 0;
        if (!rv && !m_discard) begin
          e = '{pc: m_addr, instr: er ? NOP : rd, exc: er, code: er ? 4'd1 : 4'd0};
          have = 1;
          m_pc = m_addr + 32'd4;
          if (er) m_halted = 1;
        end
      end else if (rv) begin
        m_discard = 1;
      end
    end else if (!rv && !m_halted && space) begin
      if (m_pc[1:0] != 2'b00) begin
        e = '{pc: m_pc, instr: NOP, exc: 1'b1, code: 4'd0};
        have = 1;
        m_halted = 1;
      end else begin
        m_busy = 1; m_addr = m_pc; m_discard = 0;
      end
    end
    if (pop)  void'(mq.pop_front());
    if (have) mq.push_back(e);
    if (rv) begin
      mq.delete(); m_halted = 0; m_pc = rpc;
    end
  endtask

  task automatic compare_outputs();
    logic [31:0] ei;
    bit v;
    v  = (mq.size() != 0);
    ei = v ? mq[0].instr : NOP;
    check_eq("imem_req", bus.imem_req, m_busy);
    if (m_busy) check_eq("imem_addr", bus.imem_addr, m_addr);
    check_eq("valid_o", bus.valid_o, v);
    if (v) check_eq("pc_o", bus.pc_o, mq[0].pc);
    check_eq("instr_o", bus.instr_o, ei);
    check_eq("opcode", bus.opcode, ei[6:0]);
    check_eq("funct3", bus.funct3, ei[14:12]);
    check_eq("funct7", bus.funct7, ei[31:25]);
    check_eq("funct12", bus.funct12, ei[31:20]);
    check_eq("RaiseExcep", bus.RaiseExcep, v ? mq[0].exc : 1'b0);
    check_eq("ExcepCode", bus.ExcepCode, v ? mq[0].code : 4'd0);
  endtask

  // One clock: drive at the falling edge, advance model, compare at the next falling edge.
  task automatic step(input bit rv, input logic [31:0] rpc, input bit st,
                      input bit ak, input logic [31:0] rd, input bit er);
    bus.redirect_valid = rv; bus.redirect_pc = rpc; bus.stall = st;
    bus.imem_ack = ak; bus.imem_rdata = rd; bus.imem_err = er;
    if (ak && bus.imem_req) fetched.push_back(bus.imem_addr);
    model_step(rv, rpc, st, ak, rd, er);
    @(posedge clk);
    @(negedge clk);
    if (bus.imem_req) n_req_seen++;
    compare_outputs();
  endtask

  task automatic run(input int n, input bit st);
    for (int i = 0; i < n; i++) step(0, 32'd0, st, m_busy, $urandom, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.redirect_valid = 0; bus.redirect_pc = '0; bus.stall = 0;
    bus.imem_ack = 0; bus.imem_rdata = '0; bus.imem_err = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] pc_mid, rpc;
    int n;
    do_reset();
    check_eq("rst_imem_req", bus.imem_req, 0);
    check_eq("rst_valid_o", bus.valid_o, 0);
    check_eq("rst_instr_o", bus.instr_o, NOP);
    check_eq("rst_RaiseExcep", bus.RaiseExcep, 0);
    check_eq("rst_ExcepCode", bus.ExcepCode, 0);

    // Sequential fetch from RESET_PC with immediate acks.
    fetched.delete();
    run(8, 0);
    check_eq("seq_count_ge3", fetched.size() >= 3, 1);
    if (fetched.size() >= 3) begin
      check_eq("seq_addr0", fetched[0], 32'h100);
      check_eq("seq_addr1", fetched[1], 32'h104);
      check_eq("seq_addr2", fetched[2], 32'h108);
    end

    // Stall for 10 cycles: buffer fills to its effective depth, requests stop.
    run(5, 1);
    pc_mid = bus.pc_o;
    run(5, 1);
    check_eq("stall_req_low", bus.imem_req, 0);
    check_eq("stall_valid", bus.valid_o, 1);
    check_eq("stall_pc_held", bus.pc_o, pc_mid);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (!bus.valid_o) break;
      n++;
      step(0, 32'd0, 0, 0, $urandom, 0);
    end
    check_eq("stall_buffered", n, EFF);

    // Redirect while waiting for 0x104: that word is discarded.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      if (m_busy && m_addr == 32'h104) break;
      step(0, 32'd0, 0, m_busy && m_addr == 32'h100, $urandom, 0);
    end
    check_eq("wait104_addr", bus.imem_addr, 32'h104);
    step(1, 32'h2000, 0, 0, $urandom, 0);
    step(0, 32'd0, 0, 1, 32'hDEAD_BEEF, 0);
    fetched.delete();
    for (int i = 0; i < 10; i++) begin
      if (bus.valid_o) break;
      step(0, 32'd0, 0, m_busy, $urandom, 0);
    end
    check_eq("redir_first_addr", fetched.size() > 0 ? fetched[0] : 32'hX, 32'h2000);
    check_eq("redir_first_pc", bus.pc_o, 32'h2000);

    // Misaligned redirect: exception entry, no request.
    step(1, 32'h2002, 1, 0, $urandom, 0);
    n_req_seen = 0;
    run(4, 1);
    check_eq("mis_req_count", n_req_seen, 0);
    check_eq("mis_valid", bus.valid_o, 1);
    check_eq("mis_pc", bus.pc_o, 32'h2002);
    check_eq("mis_raise", bus.RaiseExcep, 1);
    check_eq("mis_code", bus.ExcepCode, 0);
    check_eq("mis_opcode", bus.opcode, 7'h13);

    // Access fault on 0x300 halts fetching.
    step(1, 32'h300, 1, 0, $urandom, 0);
    for (int i = 0; i < 6; i++) step(0, 32'd0, 1, m_busy, $urandom, m_busy && m_addr == 32'h300);
    check_eq("err_raise", bus.RaiseExcep, 1);
    check_eq("err_code", bus.ExcepCode, 1);
    check_eq("err_instr", bus.instr_o, NOP);
    n_req_seen = 0;
    run(8, 0);
    check_eq("err_req_count", n_req_seen, 0);

    // Redirect plus pop with a full buffer.
    step(1, 32'h400, 1, 0, $urandom, 0);
    run(8, 1);
    check_eq("full_valid", bus.valid_o, 1);
    step(1, 32'h500, 0, 0, $urandom, 0);
    check_eq("flush_valid", bus.valid_o, 0);
    for (int i = 0; i < 10; i++) begin
      if (bus.valid_o) break;
      step(0, 32'd0, 0, m_busy, $urandom, 0);
    end
    check_eq("flush_target_pc", bus.pc_o, 32'h500);

    // PC wrap at the top of the address space.
    step(1, 32'hFFFF_FFFC, 0, 0, $urandom, 0);
    fetched.delete();
    run(8, 0);
    check_eq("wrap_count_ge2", fetched.size() >= 2, 1);
    if (fetched.size() >= 2) begin
      check_eq("wrap_addr0", fetched[0], 32'hFFFF_FFFC);
      check_eq("wrap_addr1", fetched[1], 32'h0);
    end

    // Reset with a request outstanding; a late ack must be ignored.
    step(1, 32'h600, 0, 0, $urandom, 0);
    run(1, 0);
    do_reset();
    step(0, 32'd0, 0, 1, 32'h1234_5678, 0);
    run(4, 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      bit rv, st, ak, er;
      rv  = ($urandom % 24) == 0;
      st  = ($urandom % 3) == 0;
      ak  = m_busy && ($urandom % 2 == 0);
      er  = ($urandom % 20) == 0;
      rpc = ($urandom % 8 == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_FFFC);
      if ($urandom % 4 == 0) rpc[1:0] = 2'($urandom_range(1, 3));
      step(rv, rpc, st, ak, $urandom, er);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
